// File: rtl/sync_down_counter.sv
// sync_down_counter: synchronous parameterised down counter with parallel load,
// count enable and a combinational terminal-count (borrow-out) for cascading.
// Optional macro DOWN_CNT_ONESHOT_EN: when defined, the counter parks at zero
// instead of wrapping to all-ones; when undefined it is free-running.
module sync_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             t,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             zero_c;

  assign zero_c = (q_q == '0);

  // Next count: load beats decrement, decrement beats hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (t) begin
`ifdef DOWN_CNT_ONESHOT_EN
      if (!zero_c) begin
        q_d = q_q - WIDTH'(1);
      end
`else
      q_d = q_q - WIDTH'(1);
`endif
    end
  end

  // Count register; reset clears it immediately, independent of clk.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;
  // Borrow-out feeds the enable of the next stage in a cascade.
  assign tc = t & zero_c;

endmodule

// File: tb/tb_sync_down_counter.sv
// Testbench for sync_down_counter: directed vectors with literal expectations
// plus a per-cycle comparison against an arithmetic reference count.
module tb_sync_down_counter;

`ifdef DOWN_CNT_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic       clk;
  logic       res;
  logic       t;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] qb;
  logic       tc;

  // Two-stage cascade forming an 8-bit counter
  logic       t_c;
  logic       load_c;
  logic [7:0] d_c;
  logic [3:0] q_lo;
  logic [3:0] qb_lo;
  logic       tc_lo;
  logic [3:0] q_hi;
  logic [3:0] qb_hi;
  logic       tc_hi;

  int n_checks = 0;
  int n_fail   = 0;
  int m        = 0;
  int m8       = 0;

  sync_down_counter #(.WIDTH(4)) dut (
    .clk(clk), .res(res), .t(t), .load(load), .d(d),
    .q(q), .qb(qb), .tc(tc)
  );

  sync_down_counter #(.WIDTH(4)) u_lo (
    .clk(clk), .res(res), .t(t_c), .load(load_c), .d(d_c[3:0]),
    .q(q_lo), .qb(qb_lo), .tc(tc_lo)
  );

  sync_down_counter #(.WIDTH(4)) u_hi (
    .clk(clk), .res(res), .t(tc_lo), .load(load_c), .d(d_c[7:4]),
    .q(q_hi), .qb(qb_hi), .tc(tc_hi)
  );

  // Clock: posedges at 7, 17, 27 ... so the 15 ns reset release falls between edges
  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference count: plain arithmetic on integers
  always @(posedge clk) begin
    if (!res) begin
      if (load) m = int'(d);
      else if (t) m = (ONESHOT && m == 0) ? 0 : (m + 15) % 16;
      if (load_c) m8 = int'(d_c);
      else if (t_c) m8 = (m8 + 255) % 256;
    end
  end

  always @(posedge res) begin
    m  = 0;
    m8 = 0;
  end

  // Per-cycle compare, mid-cycle away from the active edge
  always @(negedge clk) begin
    chk("cyc_q", int'(q), m);
    chk("cyc_qb", int'(qb), 15 - m);
    chk("cyc_tc", int'(tc), (t && m == 0) ? 1 : 0);
`ifndef DOWN_CNT_ONESHOT_EN
    chk("cyc_q8", int'({q_hi, q_lo}), m8);
    chk("cyc_tc8", int'(tc_hi), (t_c && m8 == 0) ? 1 : 0);
`endif
  end

  initial begin
    res = 1'b1; t = 1'b1; load = 1'b0; d = 4'd0;
    t_c = 1'b0; load_c = 1'b0; d_c = 8'h00;

    // 1: reset, then free count from zero
    #12;
    chk("rst_q", int'(q), 0);
    chk("rst_qb", int'(qb), 15);
    chk("rst_tc", int'(tc), 1);
    #3 res = 1'b0;
    tick(); chk("t1_q_a", int'(q), ONESHOT ? 0 : 15);
    chk("t1_tc_a", int'(tc), ONESHOT ? 1 : 0);
    tick(); chk("t1_q_b", int'(q), ONESHOT ? 0 : 14);
    tick(); chk("t1_q_c", int'(q), ONESHOT ? 0 : 13);

    // 2: load wins over t on the load edge
    load = 1'b1; d = 4'd5;
    tick(); chk("t2_load", int'(q), 5);
    load = 1'b0;
    tick(); chk("t2_q4", int'(q), 4);
    tick(); chk("t2_q3", int'(q), 3);
    tick(); chk("t2_q2", int'(q), 2);

    // 3: hold with t=0
    load = 1'b1; d = 4'd7; t = 1'b0;
    tick(); chk("t3_load", int'(q), 7);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("t3_hold", int'(q), 7);
      chk("t3_tc", int'(tc), 0);
    end
    t = 1'b1;
    tick(); chk("t3_dec", int'(q), 6);

    // 4: async reset between edges
    load = 1'b1; d = 4'd9;
    tick(); chk("t4_load", int'(q), 9);
    load = 1'b0;
    #2 res = 1'b1;
    #1 chk("t4_async_q", int'(q), 0);
    chk("t4_async_qb", int'(qb), 15);
    #2 res = 1'b0;
    tick(); chk("t4_release", int'(q), ONESHOT ? 0 : 15);

    // Boundary: tc follows t combinationally at q=0
    load = 1'b1; d = 4'd0; t = 1'b0;
    tick(); chk("bz_q", int'(q), 0);
    chk("bz_tc0", int'(tc), 0);
    load = 1'b0; t = 1'b1;
    #1 chk("bz_tc1", int'(tc), 1);
    tick(); chk("bz_wrap", int'(q), ONESHOT ? 0 : 15);

`ifdef DOWN_CNT_ONESHOT_EN
    // 6: one-shot parking at zero
    load = 1'b1; d = 4'd2; t = 1'b1;
    tick(); chk("t6_q2", int'(q), 2);
    load = 1'b0;
    tick(); chk("t6_q1", int'(q), 1);
    tick(); chk("t6_q0a", int'(q), 0);
    chk("t6_tc", int'(tc), 1);
    tick(); chk("t6_q0b", int'(q), 0);
    tick(); chk("t6_q0c", int'(q), 0);
    chk("t6_tc_park", int'(tc), 1);
    load = 1'b1; d = 4'd3;
    tick(); chk("t6_q3", int'(q), 3);
    load = 1'b0;
    tick(); chk("t6_q2b", int'(q), 2);
`else
    // 5: 8-bit cascade, borrow propagates through tc_lo
    t = 1'b0;
    load_c = 1'b1; d_c = 8'h10; t_c = 1'b1;
    tick(); chk("t5_load10", int'({q_hi, q_lo}), 16);
    load_c = 1'b0;
    tick(); chk("t5_0f", int'({q_hi, q_lo}), 15);
    tick(); chk("t5_0e", int'({q_hi, q_lo}), 14);
    load_c = 1'b1; d_c = 8'h00;
    tick(); chk("t5_load00", int'({q_hi, q_lo}), 0);
    chk("t5_tc_lo", int'(tc_lo), 1);
    chk("t5_tc_hi", int'(tc_hi), 1);
    load_c = 1'b0;
    tick(); chk("t5_ff", int'({q_hi, q_lo}), 255);
    chk("t5_tc_lo_ff", int'(tc_lo), 0);
    tick(); chk("t5_fe", int'({q_hi, q_lo}), 254);
`endif

    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
